i2c_byte_controller: RTL and testbench

Byte-level I2C master sequencer that sits directly upstream of the 8-bit `shift_register`, driving its `load`/`shift`/`inb`/`ins` ports and consuming its parallel `out`. It generates SCL timing, START, repeated START and STOP conditions, serialises one byte per command MSB-first from `out[7]`, samples SDA into the register, and handles the 9th (ACK) bit. Pins are open-drain style: the controller only ever releases a line (1) or pulls it low (0).

---
 rtl/i2c_byte_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_i2c_byte_controller.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_controller.sv
// Byte-level I2C master sequencer: drives an external 8-bit shift register and
// generates SCL/SDA for START, repeated START, one data byte + ACK, and STOP.
module i2c_byte_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic [7:0] tx_data,
    input  logic       ack_in,
    output logic [7:0] rx_data,
    output logic       ack_out,
    output logic       done,
    output logic       busy,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       sda_i,
    output logic       sr_load,
    output logic       sr_shift,
    output logic       sr_inb,
    output logic [7:0] sr_ins,
    input  logic [7:0] sr_out
);

    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4,
        S_WAIT  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [2:0]       bit_q, bit_d;
    logic             read_q, read_d;
    logic             stop_q, stop_d;
    logic             scl_q, scl_d;
    logic             sda_q, sda_d;
    logic [7:0]       rx_q, rx_d;
    logic             ack_q, ack_d;
    logic             done_q, done_d;

    logic ready_s, accept_s, tick_s, qend_s, shift_s, boundary_s, active_s;

    assign ready_s  = (state_q == S_IDLE) || (state_q == S_WAIT);
    assign active_s = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_ACK)   || (state_q == S_STOP);
    assign accept_s = cmd_valid & ready_s;
    assign tick_s   = (div_q == DIV_W'(CLK_DIV - 1));
    assign qend_s   = tick_s && (qtr_q == 2'd3);

    // Next-state, counters, command capture and line-drive selection
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        read_d     = read_q;
        stop_d     = stop_q;
        scl_d      = scl_q;
        sda_d      = sda_q;
        rx_d       = rx_q;
        ack_d      = ack_q;
        done_d     = 1'b0;
        shift_s    = 1'b0;
        boundary_s = 1'b0;

        if (active_s) begin
            boundary_s = tick_s;
            if (tick_s) begin
                div_d = '0;
                qtr_d = qtr_q + 2'd1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            div_d = '0;
            qtr_d = 2'd0;
        end

        case (state_q)
            S_IDLE, S_WAIT: begin
                if (accept_s) begin
                    // From IDLE a START is mandatory regardless of cmd_start
                    state_d    = ((state_q == S_IDLE) || cmd_start) ? S_START : S_DATA;
                    read_d     = cmd_read;
                    stop_d     = cmd_stop;
                    bit_d      = 3'd0;
                    boundary_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_START: begin
                if (qend_s) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (qend_s) begin
                    shift_s = 1'b1;
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? S_ACK : S_DATA;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_ACK: begin
                if (qend_s) begin
                    state_d = stop_q ? S_STOP : S_WAIT;
                    rx_d    = sr_out;
                    ack_d   = read_q ? ack_q : sda_i;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_ACK;
                end
            end
            S_STOP: begin
                if (qend_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (boundary_s) begin
            case (state_d)
                S_START: begin
                    case (qtr_d)
                        2'd0:    begin scl_d = scl_q; sda_d = 1'b1; end
                        2'd1:    begin scl_d = 1'b1;  sda_d = 1'b1; end
                        2'd2:    begin scl_d = 1'b1;  sda_d = 1'b0; end
                        default: begin scl_d = 1'b0;  sda_d = 1'b0; end
                    endcase
                end
                S_DATA, S_ACK: begin
                    scl_d = qtr_d[1];
                    sda_d = sda_q;
                end
                S_STOP: begin
                    case (qtr_d)
                        2'd0:    begin scl_d = 1'b0; sda_d = 1'b0; end
                        2'd1:    begin scl_d = 1'b1; sda_d = 1'b0; end
                        default: begin scl_d = 1'b1; sda_d = 1'b1; end
                    endcase
                end
                S_WAIT: begin
                    scl_d = 1'b0;
                    sda_d = 1'b0;
                end
                default: begin
                    scl_d = 1'b1;
                    sda_d = 1'b1;
                end
            endcase
        end else if ((qtr_q == 2'd0) && (div_q == '0)) begin
            // SDA updates one clock into q0 so it sees sr_out after the previous shift
            if (state_q == S_DATA) begin
                sda_d = sr_out[7];
            end else if (state_q == S_ACK) begin
                sda_d = read_q ? ack_in : 1'b1;
            end else begin
                sda_d = sda_q;
            end
        end else begin
            sda_d = sda_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            qtr_q   <= 2'd0;
            bit_q   <= 3'd0;
            read_q  <= 1'b0;
            stop_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            rx_q    <= 8'h00;
            ack_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            read_q  <= read_d;
            stop_q  <= stop_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            rx_q    <= rx_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = ready_s;
    assign busy      = active_s;
    assign scl_o     = scl_q;
    assign sda_o     = sda_q;
    assign rx_data   = rx_q;
    assign ack_out   = ack_q;
    assign done      = done_q;
    assign sr_load   = accept_s;
    assign sr_ins    = cmd_read ? 8'hFF : tx_data;
    assign sr_shift  = shift_s;
    assign sr_inb    = shift_s & sda_i;

endmodule

// File: tb/tb_i2c_byte_controller.sv
// Self-checking bench for i2c_byte_controller: models the shift register and an
// I2C slave, and checks bit timing, done latency and results through a scoreboard.
module tb_i2c_byte_controller;

    localparam int D = 4;

    logic       clock, reset_n;
    logic       cmd_valid, cmd_ready, cmd_start, cmd_stop, cmd_read;
    logic [7:0] tx_data, rx_data, sr_ins, sr_out;
    logic       ack_in, ack_out, done, busy, scl_o, sda_o, sda_i;
    logic       sr_load, sr_shift, sr_inb;
    logic       slave_sda;
    logic [7:0] sr_q;

    typedef struct packed {
        logic [7:0] rx;
        logic       ack;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic exp_ack  = 1'b1;
    bit   bus_held = 1'b0;

    i2c_byte_controller #(.CLK_DIV(D)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start),
        .cmd_stop(cmd_stop), .cmd_read(cmd_read), .tx_data(tx_data),
        .ack_in(ack_in), .rx_data(rx_data), .ack_out(ack_out), .done(done),
        .busy(busy), .scl_o(scl_o), .sda_o(sda_o), .sda_i(sda_i),
        .sr_load(sr_load), .sr_shift(sr_shift), .sr_inb(sr_inb),
        .sr_ins(sr_ins), .sr_out(sr_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Open-drain bus: line is low if either side pulls it low
    assign sda_i  = sda_o & slave_sda;
    assign sr_out = sr_q;

    // Reference 8-bit shift register sitting downstream of the controller
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      sr_q <= 8'h00;
        else if (sr_load)  sr_q <= sr_ins;
        else if (sr_shift) sr_q <= {sr_q[6:0], sr_inb};
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if ({scl_o, sda_o, cmd_ready, busy, done} !== 5'b11100) begin
            bad++;
            $display("FAIL reset_lines: scl/sda/ready/busy/done=%b required 11100",
                     {scl_o, sda_o, cmd_ready, busy, done});
        end
        total++;
        if (rx_data !== 8'h00 || ack_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_results: rx=%h ack=%b required 00/1", rx_data, ack_out);
        end
        total++;
        if ({sr_load, sr_shift, sr_inb} !== 3'b000) begin
            bad++;
            $display("FAIL reset_sr_ctrl: got %b required 000", {sr_load, sr_shift, sr_inb});
        end
        reset_n = 1'b1;
        exp_ack  = 1'b1;
        bus_held = 1'b0;
        @(negedge clock);
    endtask

    // Issue one command and follow it cycle by cycle until IDLE/WAIT
    task automatic run_cmd(input bit st, input bit sp, input bit rd, input logic [7:0] tx,
                           input logic [7:0] slv_byte, input bit ackin, input bit slv_ack,
                           input bit glitch);
        int   hdr, lat, last, rises, viol, b;
        bit   seen_done, seen_start, seen_stop, had_hdr;
        logic prev_scl, prev_sda, hi_sda;
        logic [8:0] cap, exp_bits;
        exp_t e, got;
        had_hdr  = !bus_held || st;
        hdr      = had_hdr ? 4 * D : 0;
        lat      = hdr + 36 * D;
        last     = sp ? lat + 4 * D : lat;
        e.rx     = rd ? slv_byte : tx;
        e.ack    = rd ? exp_ack : slv_ack;
        exp_ack  = e.ack;
        exp_bits = rd ? {8'hFF, ackin} : {tx, 1'b1};
        sb.push_back(e);
        rises = 0; viol = 0; cap = 9'h000; hi_sda = 1'b1;
        seen_done = 1'b0; seen_start = 1'b0; seen_stop = 1'b0;

        @(negedge clock);
        cmd_valid = 1'b1; cmd_start = st; cmd_stop = sp; cmd_read = rd;
        tx_data = tx; ack_in = ackin;
        #1;
        total++;
        if (sr_load !== 1'b1 || sr_ins !== (rd ? 8'hFF : tx)) begin
            bad++;
            $display("FAIL accept_load: sr_load=%b sr_ins=%h required 1/%h",
                     sr_load, sr_ins, rd ? 8'hFF : tx);
        end
        prev_scl = scl_o;
        prev_sda = sda_o;
        @(posedge clock);

        for (int c = 0; c <= last; c++) begin
            @(negedge clock);
            cmd_valid = 1'b0;
            slave_sda = 1'b1;
            if (c >= hdr && c < lat) begin
                b = (c - hdr) / (4 * D);
                slave_sda = (b < 8) ? slv_byte[7 - b] : slv_ack;
            end
            if (glitch && c == hdr + 8 * D + 1) begin
                cmd_valid = 1'b1;
                tx_data   = ~tx;
                #1;
                total++;
                if (sr_load !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_valid_ignored: sr_load=%b required 0", sr_load);
                end
            end
            #1;
            if (done === 1'b1) begin
                total++;
                if (seen_done || c != lat) begin
                    bad++;
                    $display("FAIL done_timing: done at cycle %0d required only at %0d", c, lat);
                end
                seen_done = 1'b1;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_empty: done with no expected entry");
                end else begin
                    got = sb.pop_front();
                    if (rx_data !== got.rx || ack_out !== got.ack) begin
                        bad++;
                        $display("FAIL result: rx=%h ack=%b required %h/%b",
                                 rx_data, ack_out, got.rx, got.ack);
                    end
                end
            end
            if (c >= hdr && c < lat) begin
                if (scl_o && !prev_scl) begin
                    if (rises < 9) cap[8 - rises] = sda_o;
                    rises++;
                    hi_sda = sda_o;
                end else if (scl_o && prev_scl && sda_o !== hi_sda) begin
                    viol++;
                end
            end
            if (c < hdr && scl_o && prev_scl && prev_sda && !sda_o) seen_start = 1'b1;
            if (c >= lat && scl_o && prev_scl && !prev_sda && sda_o) seen_stop = 1'b1;
            if (c == last - 1) begin
                total++;
                if (cmd_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL ready_early: cmd_ready=%b at cycle %0d required 0", cmd_ready, c);
                end
            end
            if (c == last) begin
                total++;
                if (cmd_ready !== 1'b1 || busy !== 1'b0 ||
                    scl_o !== sp || sda_o !== sp) begin
                    bad++;
                    $display("FAIL end_state: ready=%b busy=%b scl=%b sda=%b required 1/0/%b/%b",
                             cmd_ready, busy, scl_o, sda_o, sp, sp);
                end
            end
            prev_scl = scl_o;
            prev_sda = sda_o;
        end
        slave_sda = 1'b1;

        total++;
        if (!seen_done) begin
            bad++;
            $display("FAIL done_missing: no done within %0d cycles", last + 1);
        end
        total++;
        if (rises != 9) begin
            bad++;
            $display("FAIL scl_pulses: %0d rising edges required 9", rises);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (cap[8 - i] !== exp_bits[8 - i]) begin
                bad++;
                $display("FAIL sda_bit%0d: got %b required %b", i, cap[8 - i], exp_bits[8 - i]);
            end
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL sda_stable: %0d changes while SCL high, required 0", viol);
        end
        total++;
        if (seen_start !== had_hdr) begin
            bad++;
            $display("FAIL start_cond: seen=%b required %b", seen_start, had_hdr);
        end
        total++;
        if (seen_stop !== sp) begin
            bad++;
            $display("FAIL stop_cond: seen=%b required %b", seen_stop, sp);
        end
        bus_held = !sp;
    endtask

    task automatic test_write_a5();
        run_cmd(1'b1, 1'b1, 1'b0, 8'hA5, 8'hFF, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_read_3c();
        run_cmd(1'b1, 1'b1, 1'b1, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_nack();
        run_cmd(1'b1, 1'b1, 1'b0, 8'h33, 8'hFF, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_wait_hold();
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            total++;
            if ({scl_o, sda_o, cmd_ready, busy} !== 4'b0010) begin
                bad++;
                $display("FAIL wait_hold: scl/sda/ready/busy=%b required 0010",
                         {scl_o, sda_o, cmd_ready, busy});
            end
        end
    endtask

    task automatic test_repeated_start();
        run_cmd(1'b1, 1'b0, 1'b0, 8'h50, 8'hFF, 1'b0, 1'b0, 1'b0);
        test_wait_hold();
        run_cmd(1'b1, 1'b1, 1'b1, 8'h00, 8'h96, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_cmd(1'b1, 1'b0, 1'b0, 8'h81, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_cmd(1'b0, 1'b1, 1'b0, 8'h7E, 8'hFF, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_valid_during_data();
        run_cmd(1'b1, 1'b1, 1'b0, 8'hC3, 8'hFF, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_data();
        @(negedge clock);
        cmd_valid = 1'b1; cmd_start = 1'b1; cmd_stop = 1'b1; cmd_read = 1'b0;
        tx_data = 8'h99; ack_in = 1'b0;
        @(posedge clock);
        // Stop inside bit 3 while SCL is low so the async release of SCL is visible
        for (int c = 0; c <= 4 * D + 12 * D + 1; c++) begin
            @(negedge clock);
            cmd_valid = 1'b0;
        end
        #1;
        total++;
        if (busy !== 1'b1 || scl_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_data_precond: busy=%b scl=%b required 1/0", busy, scl_o);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({scl_o, sda_o, busy, cmd_ready, done} !== 5'b11010) begin
            bad++;
            $display("FAIL mid_data_reset: scl/sda/busy/ready/done=%b required 11010",
                     {scl_o, sda_o, busy, cmd_ready, done});
        end
        total++;
        if (rx_data !== 8'h00 || ack_out !== 1'b1 || sr_shift !== 1'b0) begin
            bad++;
            $display("FAIL mid_data_results: rx=%h ack=%b shift=%b required 00/1/0",
                     rx_data, ack_out, sr_shift);
        end
        @(negedge clock);
        reset_n  = 1'b1;
        exp_ack  = 1'b1;
        bus_held = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;
        cmd_read = 1'b0; tx_data = 8'h00; ack_in = 1'b1; slave_sda = 1'b1;
        test_reset();
        test_write_a5();
        test_read_3c();
        test_nack();
        test_repeated_start();
        test_back_to_back();
        test_valid_during_data();
        test_reset_mid_data();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: %0d entries required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
